// File: rtl/fpd_pkg.sv
// fpd_pkg: shared encodings and constants for the floating-point divider stages
package fpd_pkg;
  typedef enum logic [1:0] {
    SP_NORMAL = 2'b00,
    SP_ZERO   = 2'b01,
    SP_INF    = 2'b10,
    SP_NAN    = 2'b11
  } special_t;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX = 255;
  localparam int FLAG_INVALID = 3;
  localparam int FLAG_OVERFLOW = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT = 0;
  localparam logic [31:0] QNAN_DEFAULT = 32'h7FC0_0000;
endpackage

// File: rtl/fpd_round_rne.sv
// fpd_round_rne: round-to-nearest-even of a 24-bit significand with guard and sticky
module fpd_round_rne (
  input  logic [23:0] sig,
  input  logic        guard,
  input  logic        sticky,
  output logic [23:0] rounded,
  output logic        carry,
  output logic        inexact
);
  logic inc;
  assign inc = guard & (sticky | sig[0]);
  assign {carry, rounded} = {1'b0, sig} + {24'b0, inc};
  assign inexact = guard | sticky;
endmodule

// File: rtl/fpd_normalize_round.sv
// fpd_normalize_round: two-stage normalize, round and pack pipeline after the mantissa divide
module fpd_normalize_round
  import fpd_pkg::*;
#(
  parameter logic [31:0] QNAN = QNAN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [25:0] in_quot,
  input  logic        in_sticky,
  input  logic [1:0]  in_special,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags
);
  logic s1_valid, s2_valid, adv1, adv2;
  logic s1_sign, s1_guard, s1_sticky;
  logic [9:0] s1_exp;
  logic [23:0] s1_sig;
  special_t s1_special;
  logic [25:0] m;
  logic [9:0] e;
  logic [23:0] rounded;
  logic carry, inexact, unused_hidden;
  logic signed [10:0] e_r;
  logic [31:0] res;
  logic [3:0] flg;
  assign adv2 = !s2_valid | out_ready;
  assign adv1 = !s1_valid | adv2;
  assign in_ready = adv1;
  assign out_valid = s2_valid;
  assign m = in_quot[25] ? in_quot : {in_quot[24:0], 1'b0};
  assign e = in_quot[25] ? in_exp : in_exp - 10'd1;
  fpd_round_rne u_round (
    .sig     (s1_sig),
    .guard   (s1_guard),
    .sticky  (s1_sticky),
    .rounded (rounded),
    .carry   (carry),
    .inexact (inexact)
  );
  assign unused_hidden = rounded[23];
  assign e_r = $signed({s1_exp[9], s1_exp}) + $signed({10'b0, carry});
  always_comb begin
    res = {s1_sign, e_r[7:0], rounded[22:0]};
    flg = '0;
    flg[FLAG_INEXACT] = inexact;
    if (int'(e_r) >= EXP_MAX) begin
      res = {s1_sign, 8'hFF, 23'h0};
      flg[FLAG_OVERFLOW] = 1'b1;
      flg[FLAG_INEXACT] = 1'b1;
    end else if (int'(e_r) <= 0) begin
      res = {s1_sign, 31'h0};
      flg[FLAG_UNDERFLOW] = 1'b1;
      flg[FLAG_INEXACT] = 1'b1;
    end
    if (s1_special != SP_NORMAL) begin
      res = s1_special == SP_NAN ? QNAN :
            s1_special == SP_INF ? {s1_sign, 8'hFF, 23'h0} : {s1_sign, 31'h0};
      flg = '0;
      flg[FLAG_INVALID] = s1_special == SP_NAN;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_sign <= 1'b0;
      s1_exp <= '0;
      s1_sig <= '0;
      s1_guard <= 1'b0;
      s1_sticky <= 1'b0;
      s1_special <= SP_NORMAL;
      out_result <= '0;
      out_flags <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sign <= in_sign;
          s1_exp <= e;
          s1_sig <= m[25:2];
          s1_guard <= m[1];
          s1_sticky <= m[0] | in_sticky;
          s1_special <= special_t'(in_special);
        end
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_result <= res;
          out_flags <= flg;
        end
      end
    end
  end
endmodule

// File: tb/tb_fpd_normalize_round.sv
// tb_fpd_normalize_round: directed scoreboard bench for the normalize/round pipeline
module tb_fpd_normalize_round;
  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic in_sign = 1'b0;
  logic [9:0] in_exp = '0;
  logic [25:0] in_quot = '0;
  logic in_sticky = 1'b0;
  logic [1:0] in_special = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [31:0] out_result;
  logic [3:0] out_flags;
  exp_t exp_q[$];
  exp_t pend;
  exp_t head;
  logic acc;
  int checks = 0;
  int errors = 0;
  fpd_normalize_round dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_quot    (in_quot),
    .in_sticky  (in_sticky),
    .in_special (in_special),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );
  always #5 clk = ~clk;
  task automatic check_bit(input string tag, input logic obs, input logic want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_output observed=%h expected=none", out_result);
      end else begin
        head = exp_q.pop_front();
        checks += 2;
        assert (out_result === head.res) else begin
          errors++;
          $error("FAIL result observed=%h expected=%h", out_result, head.res);
        end
        assert (out_flags === head.flg) else begin
          errors++;
          $error("FAIL flags observed=%b expected=%b", out_flags, head.flg);
        end
      end
    end
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(pend);
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic s, input logic [9:0] ex, input logic [25:0] q, input logic st,
                       input logic [1:0] sp, input logic [31:0] r, input logic [3:0] f);
    in_sign = s;
    in_exp = ex;
    in_quot = q;
    in_sticky = st;
    in_special = sp;
    in_valid = 1'b1;
    pend = '{res: r, flg: f};
  endtask
  task automatic send(input logic s, input logic [9:0] ex, input logic [25:0] q, input logic st,
                      input logic [1:0] sp, input logic [31:0] r, input logic [3:0] f);
    int n;
    drive(s, ex, q, st, sp, r, f);
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout observed=%0d expected<50", n);
    end
    in_valid = 1'b0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain observed=%0d expected=0 pending", exp_q.size());
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_bit("rst_out_valid", out_valid, 1'b0);
    checks += 2;
    assert (out_result === 32'h0) else begin
      errors++;
      $error("FAIL rst_result observed=%h expected=%h", out_result, 32'h0);
    end
    assert (out_flags === 4'h0) else begin
      errors++;
      $error("FAIL rst_flags observed=%b expected=%b", out_flags, 4'h0);
    end
    check_bit("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    send(1'b0, 10'd128, 26'h2000000, 1'b0, 2'b00, 32'h40000000, 4'b0000);
    send(1'b0, 10'd127, 26'h1555555, 1'b1, 2'b00, 32'h3F2AAAAB, 4'b0001);
    send(1'b0, 10'd127, 26'h3FFFFFF, 1'b0, 2'b00, 32'h40000000, 4'b0001);
    send(1'b0, 10'd127, 26'h2000002, 1'b0, 2'b00, 32'h3F800000, 4'b0001);
    send(1'b0, 10'd255, 26'h2000000, 1'b0, 2'b00, 32'h7F800000, 4'b0101);
    send(1'b1, 10'h3F0, 26'h2000000, 1'b0, 2'b00, 32'h80000000, 4'b0011);
    send(1'b0, 10'd127, 26'h2000000, 1'b0, 2'b11, 32'h7FC00000, 4'b1000);
    send(1'b1, 10'd127, 26'h2000000, 1'b0, 2'b10, 32'hFF800000, 4'b0000);
    send(1'b1, 10'd127, 26'h2000000, 1'b0, 2'b01, 32'h80000000, 4'b0000);
    send(1'b0, 10'd254, 26'h3FFFFFF, 1'b0, 2'b00, 32'h7F800000, 4'b0101);
    send(1'b0, 10'd0, 26'h3FFFFFF, 1'b0, 2'b00, 32'h00800000, 4'b0001);
    send(1'b0, 10'd1, 26'h1000000, 1'b0, 2'b00, 32'h00000000, 4'b0011);
    send(1'b1, 10'd130, 26'h3000000, 1'b0, 2'b00, 32'hC1400000, 4'b0000);
    drain();
    out_ready = 1'b0;
    send(1'b0, 10'd128, 26'h2000000, 1'b0, 2'b00, 32'h40000000, 4'b0000);
    send(1'b0, 10'd127, 26'h2000000, 1'b0, 2'b00, 32'h3F800000, 4'b0000);
    drive(1'b1, 10'd128, 26'h2000000, 1'b0, 2'b00, 32'hC0000000, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      check_bit("stall_in_ready", in_ready, 1'b0);
      check_bit("stall_out_valid", out_valid, 1'b1);
      checks++;
      assert (out_result === 32'h40000000) else begin
        errors++;
        $error("FAIL stall_hold observed=%h expected=%h", out_result, 32'h40000000);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) tick();
    check_bit("stall_accept", acc, 1'b1);
    in_valid = 1'b0;
    drain();
    out_ready = 1'b0;
    send(1'b0, 10'd128, 26'h2000000, 1'b0, 2'b00, 32'h40000000, 4'b0000);
    send(1'b0, 10'd127, 26'h2000000, 1'b0, 2'b00, 32'h3F800000, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("async_rst_out_valid", out_valid, 1'b0);
    check_bit("async_rst_in_ready", in_ready, 1'b1);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 10'd129, 26'h2000000, 1'b0, 2'b00, 32'h40800000, 4'b0000);
    tick();
    check_bit("lat_accept", acc, 1'b1);
    in_valid = 1'b0;
    check_bit("lat_cycle1", out_valid, 1'b0);
    tick();
    check_bit("lat_cycle2", out_valid, 1'b1);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
